sha3scanner_axil_regs: RTL and testbench
========================================

# sha3scanner_axil_regs

AXI4-Lite slave register file for the sha3scanner peripheral; the responder that answers the master VIP's single-beat writes and reads on S00_AXI. Holds four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC. Exposes the register contents and one-cycle per-register write strobes to the sha3scanner core. Sits between the AXI interconnect and the scanner datapath.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decodes 4 words.
- S_AXI_ACLK  in  1  the single clock.
- S_AXI_ARESET  in  1  reset; synchronous, active-high.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  read-data handshake.
- reg_q  out  128  registers, word i at bits [32i+31:32i].
- wr_pulse  out  4  bit i high for one cycle when word i is committed.

## Operation
- Word index = addr[3:2]; addr[1:0] ignored; PROT ignored; no SLVERR or DECERR ever.
- Write side: AW and W are captured independently into one-entry holding slots, in either order or in the same cycle.
- AWREADY = !aw_held && !BVALID && !ARESET; WREADY = !w_held && !BVALID && !ARESET.
- Commit happens when an address (held or handshaking this cycle) and data (held or handshaking this cycle) are both present. Commit updates the register, pulses wr_pulse, sets BVALID and clears both slots on the same edge.
- BVALID holds until BREADY. No new AW or W is accepted while BVALID is high.
- Read side: ARREADY = !RVALID && !ARESET. On the AR handshake, RDATA is latched from the current register value and RVALID is set. Both hold until RREADY.
- A read and a write commit to the same word in the same cycle return the pre-write value.
- Reset values: all registers 0, reg_q 0, wr_pulse 0, BVALID 0, RVALID 0, RDATA 0, all READY outputs 0 while reset is asserted.

## Timing
- AW/W complete in cycle k: reg_q, wr_pulse and BVALID are visible in k+1.
- AR handshake in cycle k: RVALID and RDATA in k+1.
- Throughput: one write per 2 cycles when BREADY is held high; one read per 2 cycles.
- Reset mid-operation: held AW/W slots and B/R valids are dropped. No partial transaction ever commits. READY outputs rise in the first cycle after reset deasserts.

## Configuration
- SHA3SCANNER_AXIL_WSTRB_EN defined: only bytes whose WSTRB bit is set are updated.
- Not defined: WSTRB is ignored and the full word is always written.
- wr_pulse fires on every commit in both builds, including when WSTRB = 0.

## Structure
- Package sha3scanner_axil_pkg holds:
  - register index localparams (REG_0..REG_3);
  - AXI_RESP_OKAY;
  - the word-index extraction width.
- Sub-module sha3scanner_axil_hold_slot: a one-entry valid+payload holding slot. It is instantiated once for AW (4 bits) and once for W (36 bits).

## Test plan
- Write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read the same addresses -> read data is 1,2,3,4 and every BRESP/RRESP is OKAY.
- Drive W (0xDEADBEEF) three cycles before AW (0x8) -> no BVALID until the AW handshake. BVALID is high the next cycle, reg_q[95:64] = 0xDEADBEEF, and wr_pulse = 4'b0100 for exactly one cycle.
- Hold BREADY low 5 cycles -> BVALID stays high, AWREADY/WREADY stay low, and a queued second write does not commit until after BREADY. Do the same with RREADY -> RDATA is stable and ARREADY stays low.
- Write 0x11223344 to 0x0, then 0xAABBCCDD with WSTRB 4'b0010 -> reads back 0x1122CC44 with the macro and 0xAABBCCDD without it.
- With 0x4 holding 2, hand-shake AR 0x4 in the same cycle as a write commit of 0x55 to 0x4 -> RDATA = 2, and a following read returns 0x55.
- Capture AW 0xC, pulse reset for 1 cycle, then send W 0x99 -> no commit, no BVALID, and all registers read 0.

Source files
------------

// File: rtl/sha3scanner_axil_pkg.sv
// -----------------------------------------------------------------------------
// sha3scanner_axil_pkg
// Shared constants and helpers for the sha3scanner AXI4-Lite register block.
//   - REG_0..REG_3   : word indices of the four control/status registers
//   - AXI_RESP_OKAY  : the only response code this block ever returns
//   - WORD_IDX_W/LSB : where the word index sits inside a byte address
//   - merge_wstrb()  : byte-lane merge used when strobes are honoured
// -----------------------------------------------------------------------------
package sha3scanner_axil_pkg;

    localparam int NUM_REGS = 4;
    localparam int REG_0    = 0;
    localparam int REG_1    = 1;
    localparam int REG_2    = 2;
    localparam int REG_3    = 3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Byte address -> word index: bits [WORD_IDX_LSB +: WORD_IDX_W].
    localparam int WORD_IDX_W   = 2;
    localparam int WORD_IDX_LSB = 2;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_wstrb(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sha3scanner_axil_hold_slot.sv
// -----------------------------------------------------------------------------
// sha3scanner_axil_hold_slot
// One-entry holding slot: a valid flag plus a payload register. Used to park
// an AXI address or data beat until its partner channel arrives.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_load, i_data    capture i_data and mark the slot valid
//   i_clear           empty the slot (wins over i_load)
//   o_valid, o_data   slot state
// -----------------------------------------------------------------------------
module sha3scanner_axil_hold_slot #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // NOTE: sequential state always uses non-blocking (<=) assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    // NOTE: the payload carries no reset; it is only ever read while r_valid
    // is set, so resetting it would buy nothing.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/sha3scanner_axil_regs.sv
// -----------------------------------------------------------------------------
// sha3scanner_axil_regs
// AXI4-Lite slave holding four 32-bit R/W registers at byte offsets 0x0..0xC
// for the sha3scanner core. AW and W are accepted independently (either order
// or together); a write commits once both are present. Reads return the
// register value at the AR handshake. Responses are always OKAY.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET   clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*            write address / data / response channels
//   S_AXI_AR*/R*               read address / data channels
//   reg_q                      register contents, word i at [32i+31:32i]
//   wr_pulse                   one-cycle strobe per register on each commit
// Build option:
//   SHA3SCANNER_AXIL_WSTRB_EN  defined: honour WSTRB byte lanes;
//                              undefined: always write the full word.
// -----------------------------------------------------------------------------
module sha3scanner_axil_regs
    import sha3scanner_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]               wr_pulse
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    logic [NUM_REGS-1:0][DW-1:0] r_regs;
    logic [NUM_REGS-1:0]         r_wr_pulse;
    logic                        r_bvalid;
    logic                        r_rvalid;
    logic [DW-1:0]               r_rdata;

    logic                  w_aw_held;
    logic [AW-1:0]         w_aw_slot;
    logic                  w_w_held;
    logic [SW+DW-1:0]      w_w_slot;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [AW-1:0]         w_addr;
    logic [DW-1:0]         w_wdata;
    logic [SW-1:0]         w_wstrb;
    logic [WORD_IDX_W-1:0] w_aw_idx;
    logic [WORD_IDX_W-1:0] w_ar_idx;
    logic [NUM_REGS-1:0]   w_sel;
    logic [DW-1:0]         w_new_word;
    logic                  w_unused;

    // ---------------- handshakes ----------------
    assign S_AXI_AWREADY = !w_aw_held && !r_bvalid && !S_AXI_ARESET;
    assign S_AXI_WREADY  = !w_w_held  && !r_bvalid && !S_AXI_ARESET;
    assign S_AXI_ARREADY = !r_rvalid  && !S_AXI_ARESET;

    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A beat is "present" if parked in its slot or handshaking right now, so
    // a same-cycle AW+W commits without ever touching the slots.
    assign w_commit = (w_aw_held || w_aw_hs) && (w_w_held || w_w_hs);

    assign w_addr               = w_aw_held ? w_aw_slot : S_AXI_AWADDR;
    assign {w_wstrb, w_wdata}   = w_w_held  ? w_w_slot  : {S_AXI_WSTRB, S_AXI_WDATA};
    assign w_aw_idx             = w_addr[WORD_IDX_LSB +: WORD_IDX_W];
    assign w_ar_idx             = S_AXI_ARADDR[WORD_IDX_LSB +: WORD_IDX_W];

    // Slots clear on commit; clear outranks load inside the slot, so a beat
    // that handshakes in its commit cycle is never parked.
    sha3scanner_axil_hold_slot #(.W(AW)) u_aw_slot (
        .i_clk   (S_AXI_ACLK),
        .i_rst   (S_AXI_ARESET),
        .i_load  (w_aw_hs),
        .i_clear (w_commit),
        .i_data  (S_AXI_AWADDR),
        .o_valid (w_aw_held),
        .o_data  (w_aw_slot)
    );

    sha3scanner_axil_hold_slot #(.W(SW+DW)) u_w_slot (
        .i_clk   (S_AXI_ACLK),
        .i_rst   (S_AXI_ARESET),
        .i_load  (w_w_hs),
        .i_clear (w_commit),
        .i_data  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .o_valid (w_w_held),
        .o_data  (w_w_slot)
    );

    // ---------------- write decode ----------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_sel = '0;
        case (w_aw_idx)
            WORD_IDX_W'(REG_0): w_sel[REG_0] = 1'b1;
            WORD_IDX_W'(REG_1): w_sel[REG_1] = 1'b1;
            WORD_IDX_W'(REG_2): w_sel[REG_2] = 1'b1;
            default:            w_sel[REG_3] = 1'b1;
        endcase
    end

`ifdef SHA3SCANNER_AXIL_WSTRB_EN
    assign w_new_word = merge_wstrb(r_regs[w_aw_idx], w_wdata, w_wstrb);
`else
    assign w_new_word = w_wdata;
`endif

    // ---------------- state ----------------
    // The read capture samples r_regs before this edge's write lands, so a
    // same-cycle read/write to one word returns the old value.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_regs     <= '0;
            r_wr_pulse <= '0;
            r_bvalid   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_wr_pulse <= w_commit ? w_sel : '0;

            if (w_commit) begin
                r_regs[w_aw_idx] <= w_new_word;
            end

            if (w_commit) begin
                r_bvalid <= 1'b1;
            end else if (S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end

            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_regs[w_ar_idx];
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- outputs ----------------
    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = AXI_RESP_OKAY;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = AXI_RESP_OKAY;
    assign reg_q        = r_regs;
    assign wr_pulse     = r_wr_pulse;

    // PROT, the byte-offset address bits and (in the full-word build) WSTRB
    // carry no meaning here.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        w_addr[WORD_IDX_LSB-1:0], S_AXI_ARADDR[WORD_IDX_LSB-1:0],
                        w_wstrb};

endmodule

// File: tb/tb_sha3scanner_axil_regs.sv
// -----------------------------------------------------------------------------
// tb_sha3scanner_axil_regs
// Self-checking bench for sha3scanner_axil_regs. A register model tracks
// expected contents; read expectations are queued when a read is issued and
// compared when RVALID appears. Inputs change and outputs are sampled 1 time
// unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sha3scanner_axil_regs;

    logic         clk = 1'b0;
    logic         S_AXI_ARESET;
    logic [3:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [3:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] reg_q;
    logic [3:0]   wr_pulse;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl [4];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    sha3scanner_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (S_AXI_ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_q         (reg_q),
        .wr_pulse      (wr_pulse)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
        logic [31:0] r;
`ifdef SHA3SCANNER_AXIL_WSTRB_EN
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
`else
        r = new_w;
        if (strb == 4'hx) r = old_w;  // never taken; keeps arguments referenced
`endif
        return r;
    endfunction

    function automatic logic [127:0] mdl_flat();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write with BREADY high: drive AW+W, wait for both handshakes,
    // check the commit, then let the B handshake finish.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_fire, w_fire, aw_done, w_done;
        int cyc;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data;  S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            cyc++;
            if (aw_fire) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
            if (w_fire)  begin S_AXI_WVALID = 1'b0;  w_done = 1;  end
        end
        if (!(aw_done && w_done)) begin
            check("wr_timeout", 1'b0, 1'b1);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        end else begin
            mdl[addr[3:2]] = mdl_merge(mdl[addr[3:2]], data, strb);
            check("wr_bvalid", S_AXI_BVALID, 1'b1);
            check("wr_bresp", S_AXI_BRESP, 2'b00);
            check("wr_reg_q", reg_q, mdl_flat());
        end
        tick();
    endtask

    // Full read with RREADY high: expectation queued at issue, compared on RVALID.
    task automatic axi_read(input logic [3:0] addr);
        bit ar_done, got;
        int cyc;
        exp_q.push_back(mdl[addr[3:2]]);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        ar_done = 0; cyc = 0;
        while (!ar_done && cyc < 20) begin
            ar_done = S_AXI_ARVALID && S_AXI_ARREADY;
            tick();
            cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        got = 0; cyc = 0;
        while (ar_done && !got && cyc < 20) begin
            if (S_AXI_RVALID) got = 1;
            else begin tick(); cyc++; end
        end
        if (!got) begin
            check("rd_timeout", 1'b0, 1'b1);
            void'(exp_q.pop_front());
        end else begin
            check("rd_data", S_AXI_RDATA, exp_q.pop_front());
            check("rd_resp", S_AXI_RRESP, 2'b00);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] e;
        S_AXI_ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0;  S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = '0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        check("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        S_AXI_ARESET = 1'b0;
        #1;
        check("post_rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        check("post_rst_reg_q", reg_q, 128'h0);
        check("post_rst_rdata", S_AXI_RDATA, 32'h0);
        check("post_rst_pulse", wr_pulse, 4'h0);
        tick();

        // ---- basic writes then reads ----
        for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4));

        // ---- W three cycles ahead of AW ----
        S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        check("wfirst_wready", S_AXI_WREADY, 1'b1);
        tick();
        S_AXI_WVALID = 1'b0;
        check("wfirst_wready_held", S_AXI_WREADY, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("wfirst_no_bvalid", S_AXI_BVALID, 1'b0);
            check("wfirst_no_pulse", wr_pulse, 4'h0);
            tick();
        end
        S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
        check("wfirst_awready", S_AXI_AWREADY, 1'b1);
        tick();
        S_AXI_AWVALID = 1'b0;
        mdl[2] = 32'hDEADBEEF;
        check("wfirst_bvalid", S_AXI_BVALID, 1'b1);
        check("wfirst_reg2", reg_q[95:64], 32'hDEADBEEF);
        check("wfirst_pulse", wr_pulse, 4'b0100);
        tick();
        check("wfirst_pulse_gone", wr_pulse, 4'h0);
        check("wfirst_bvalid_gone", S_AXI_BVALID, 1'b0);

        // ---- BREADY held low with a second write queued ----
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'hA5A50001; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        mdl[0] = 32'hA5A50001;
        check("bstall_first_commit", reg_q, mdl_flat());
        S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h0BADF00D;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bstall_bvalid", S_AXI_BVALID, 1'b1);
            check("bstall_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
            check("bstall_no_commit", reg_q[63:32], mdl[1]);
            tick();
        end
        S_AXI_BREADY = 1'b1;
        tick();
        check("bstall_released", S_AXI_BVALID, 1'b0);
        check("bstall_still_old", reg_q[63:32], mdl[1]);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        mdl[1] = 32'h0BADF00D;
        check("bstall_second_bvalid", S_AXI_BVALID, 1'b1);
        check("bstall_second_reg", reg_q, mdl_flat());
        check("bstall_second_pulse", wr_pulse, 4'b0010);
        tick();

        // ---- RREADY held low ----
        S_AXI_RREADY = 1'b0;
        exp_q.push_back(mdl[0]);
        S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        check("rstall_rvalid", S_AXI_RVALID, 1'b1);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("rstall_rdata", S_AXI_RDATA, e);
            check("rstall_arready", S_AXI_ARREADY, 1'b0);
            tick();
        end
        S_AXI_RREADY = 1'b1;
        tick();
        check("rstall_released", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b01);

        // ---- write strobes ----
        axi_write(4'h0, 32'h11223344, 4'hF);
        axi_write(4'h0, 32'hAABBCCDD, 4'b0010);
`ifdef SHA3SCANNER_AXIL_WSTRB_EN
        check("wstrb_word", reg_q[31:0], 32'h1122CC44);
`else
        check("wstrb_word", reg_q[31:0], 32'hAABBCCDD);
`endif
        axi_read(4'h0);

        // ---- same-cycle read and write to one word ----
        axi_write(4'h4, 32'h2, 4'hF);
        exp_q.push_back(mdl[1]);
        S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 4'h4;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        check("rw_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        mdl[1] = 32'h55;
        check("rw_rvalid", S_AXI_RVALID, 1'b1);
        check("rw_old_value", S_AXI_RDATA, exp_q.pop_front());
        check("rw_reg_q", reg_q, mdl_flat());
        tick();
        axi_read(4'h4);

        // ---- reset drops a parked AW ----
        S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        check("rst_aw_held", S_AXI_AWREADY, 1'b0);
        S_AXI_ARESET = 1'b1;
        #1;
        check("rst_mid_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        tick();
        S_AXI_ARESET = 1'b0;
        #1;
        check("rst_mid_awready", S_AXI_AWREADY, 1'b1);
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        check("rst_no_bvalid", S_AXI_BVALID, 1'b0);
        check("rst_no_pulse", wr_pulse, 4'h0);
        check("rst_reg_q", reg_q, 128'h0);
        tick();
        check("rst_no_bvalid_late", S_AXI_BVALID, 1'b0);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
